// File: rtl/kbd_evt_pkg.sv
// Shared types for the keycode event decoder: FSM states, event record, report helpers.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package kbd_evt_pkg;

  localparam int         NSLOTS   = 8;
  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE,
    SCAN_PRESS,
    SCAN_REL,
    COMMIT
  } kbd_state_t;

  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } kbd_evt_t;

  // Number of distinct non-zero keycodes in a report; duplicates count once.
  function automatic logic [3:0] count_distinct(input logic [NSLOTS*8-1:0] rep);
    logic [3:0] n;
    logic       dup;
    n = '0;
    for (int i = 0; i < NSLOTS; i++) begin
      dup = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (rep[8*j +: 8] == rep[8*i +: 8]) dup = 1'b1;
      end
      if (rep[8*i +: 8] != KEY_NONE && !dup) n = n + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/kbd_evt_fifo.sv
// Synchronous FIFO of key events with a live count.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: can_push drops when full unless a pop happens in the same cycle; pop on empty is ignored.
module kbd_evt_fifo
  import kbd_evt_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   Clk,
  input  logic                   reset_rtl_0,
  input  logic                   push,
  input  kbd_evt_t               din,
  output logic                   can_push,
  input  logic                   pop,
  output kbd_evt_t               dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  kbd_evt_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_en;
  logic          pop_en;

  assign valid    = (count != '0);
  assign pop_en   = pop && valid;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO can still accept.
  assign can_push = (count != FULL) || pop_en;
  assign push_en  = push && can_push;
  assign dout     = mem[rd_ptr];

  // Storage needs no reset: nothing is read until count says an entry exists.
  always_ff @(posedge Clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keycode_event_decoder.sv
// Diffs successive 8-slot HID keycode reports into press/release events queued in a FIFO.
// Latency: input edge E0 -> cur latched E1 -> slot k press pushed at E(2+k), releases E(10+k), commit E18.
// Backpressure: the scan holds on a slot whose event cannot be queued; no event is ever dropped.
module keycode_event_decoder
  import kbd_evt_pkg::*;
#(
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] ROLLOVER_CODE = 8'h01,
  parameter int         ERR_CNT_W     = 8
) (
  input  logic                 Clk,
  input  logic                 reset_rtl_0,
  input  logic [31:0]          keycode0_gpio,
  input  logic [31:0]          keycode1_gpio,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [7:0]           evt_code,
  output logic                 evt_press,
  output logic [3:0]           held_count,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] rollover_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = NSLOTS * 8;

  kbd_state_t    state, state_nxt;
  logic [RW-1:0] raw_q, cur, prev, last_ro;
  logic [RW-1:0] own, other;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    cand;
  logic          scan_press, has_ro, in_other, dup_earlier, need_push;
  logic          load_cur, do_commit, ro_inc;
  logic          fifo_push, fifo_pop, can_push, fifo_valid;
  logic [CW-1:0] fifo_count;
  kbd_evt_t      evt_din, evt_head;

  // Single capture stage for the GPIO report; no filtering beyond this.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) raw_q <= '0;
    else              raw_q <= {keycode1_gpio, keycode0_gpio};
  end

  // Slot comparators: the slot under idx against all 8 slots of the other report and earlier own slots.
  always_comb begin
    scan_press  = (state == SCAN_PRESS);
    own         = scan_press ? cur  : prev;
    other       = scan_press ? prev : cur;
    cand        = own[8*idx +: 8];
    in_other    = 1'b0;
    dup_earlier = 1'b0;
    has_ro      = 1'b0;
    for (int j = 0; j < NSLOTS; j++) begin
      if (other[8*j +: 8] == cand)                    in_other    = 1'b1;
      if (j < int'(idx) && own[8*j +: 8] == cand)     dup_earlier = 1'b1;
      if (raw_q[8*j +: 8] == ROLLOVER_CODE)           has_ro      = 1'b1;
    end
    need_push     = (state == SCAN_PRESS || state == SCAN_REL) &&
                    (cand != KEY_NONE) && !in_other && !dup_earlier;
    evt_din.press = scan_press;
    evt_din.code  = cand;
  end

  // Next-state logic; a rollover report is counted once per distinct report seen while idle.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load_cur  = 1'b0;
    do_commit = 1'b0;
    ro_inc    = 1'b0;
    fifo_push = 1'b0;
    case (state)
      IDLE: begin
        if (has_ro) begin
          ro_inc = (raw_q != last_ro);
        end else if (raw_q != prev) begin
          load_cur  = 1'b1;
          idx_nxt   = '0;
          state_nxt = SCAN_PRESS;
        end
      end
      SCAN_PRESS, SCAN_REL: begin
        if (!need_push || can_push) begin
          fifo_push = need_push;
          idx_nxt   = idx + 3'd1;
          if (idx == 3'(NSLOTS - 1)) state_nxt = scan_press ? SCAN_REL : COMMIT;
        end
      end
      COMMIT: begin
        do_commit = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, scan index, report snapshots and status counters.
  always_ff @(posedge Clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state        <= IDLE;
      idx          <= '0;
      cur          <= '0;
      prev         <= '0;
      last_ro      <= '0;
      held_count   <= '0;
      rollover_cnt <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (load_cur) cur <= raw_q;
      if (do_commit) begin
        prev       <= cur;
        held_count <= count_distinct(cur);
      end
      // All-zero never contains the rollover code, so it doubles as "nothing counted yet".
      if (state == IDLE) last_ro <= has_ro ? raw_q : '0;
      if (ro_inc && rollover_cnt != {ERR_CNT_W{1'b1}})
        rollover_cnt <= rollover_cnt + ERR_CNT_W'(1);
    end
  end

  kbd_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk         (Clk),
    .reset_rtl_0 (reset_rtl_0),
    .push        (fifo_push),
    .din         (evt_din),
    .can_push    (can_push),
    .pop         (fifo_pop),
    .dout        (evt_head),
    .valid       (fifo_valid),
    .count       (fifo_count)
  );

  assign fifo_pop  = evt_valid && evt_ready;
  assign evt_valid = fifo_valid;
  // Head fields read as zero while empty, since FIFO storage is not reset.
  assign evt_code  = (fifo_count != '0) ? evt_head.code  : 8'h00;
  assign evt_press = (fifo_count != '0) ? evt_head.press : 1'b0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_keycode_event_decoder.sv
// Self-checking bench: reset, latency, table of report diffs, backpressure, rollover, async reset, random.
// Latency: n/a.
// Backpressure: evt_ready driven fixed or randomly each cycle.
module tb_keycode_event_decoder;

  logic        Clk = 1'b0;
  logic        reset_rtl_0 = 1'b0;
  logic [31:0] keycode0_gpio = '0;
  logic [31:0] keycode1_gpio = '0;
  logic        evt_valid;
  logic        evt_ready = 1'b1;
  logic [7:0]  evt_code;
  logic        evt_press;
  logic [3:0]  held_count;
  logic        busy;
  logic [7:0]  rollover_cnt;

  keycode_event_decoder dut (
    .Clk           (Clk),
    .reset_rtl_0   (reset_rtl_0),
    .keycode0_gpio (keycode0_gpio),
    .keycode1_gpio (keycode1_gpio),
    .evt_valid     (evt_valid),
    .evt_ready     (evt_ready),
    .evt_code      (evt_code),
    .evt_press     (evt_press),
    .held_count    (held_count),
    .busy          (busy),
    .rollover_cnt  (rollover_cnt)
  );

  always #5 Clk = ~Clk;

  int          tests = 0;
  int          fails = 0;
  logic [8:0]  got_q[$];
  logic [8:0]  exp_q[$];
  logic        rand_mode = 1'b0;
  logic        rdy_fixed = 1'b1;
  logic [63:0] model_prev = '0;
  int          model_ro = 0;
  int          model_held = 0;

  typedef struct {
    logic [31:0] k0;
    logic [31:0] k1;
    int          n;
    logic [8:0]  ev[4];
    logic [3:0]  held;
  } vec_t;
  vec_t tbl[8];

  // Consumer ready: changes 2 time units after the edge, away from the sampling negedge.
  always @(posedge Clk) begin
    #2;
    evt_ready = rand_mode ? 1'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Record every handshake that will complete on the coming edge.
  always @(negedge Clk) begin
    if (reset_rtl_0 && evt_valid && evt_ready) got_q.push_back({evt_press, evt_code});
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic [31:0] k0, input logic [31:0] k1);
    @(posedge Clk);
    #1;
    keycode0_gpio = k0;
    keycode1_gpio = k1;
  endtask

  // Waits until the scan is over and the FIFO has drained, with a cycle budget.
  task automatic wait_idle(input string name);
    int quiet = 0;
    int n = 0;
    repeat (3) @(negedge Clk);
    while (quiet < 2 && n < 3000) begin
      @(negedge Clk);
      n++;
      if (!busy && !evt_valid) quiet++;
      else quiet = 0;
    end
    check({name, " idle timeout"}, 64'(quiet >= 2), 64'd1);
  endtask

  task automatic compare_events(input string tag);
    check({tag, " event count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s ev%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  // Set-based reference: new keys pressed in order of first appearance, then vanished keys released.
  task automatic model_report(input logic [63:0] rep);
    logic [255:0] in_old, in_new, done;
    logic [7:0]   c;
    logic         ro;
    ro = 1'b0;
    for (int s = 0; s < 8; s++) if (rep[8*s +: 8] == 8'h01) ro = 1'b1;
    if (ro) begin
      if (model_ro < 255) model_ro++;
    end else begin
      in_old = '0;
      in_new = '0;
      for (int s = 0; s < 8; s++) begin
        if (model_prev[8*s +: 8] != 8'h00) in_old[model_prev[8*s +: 8]] = 1'b1;
        if (rep[8*s +: 8] != 8'h00)        in_new[rep[8*s +: 8]] = 1'b1;
      end
      done = '0;
      for (int s = 0; s < 8; s++) begin
        c = rep[8*s +: 8];
        if (c != 8'h00 && !in_old[c] && !done[c]) begin
          exp_q.push_back({1'b1, c});
          done[c] = 1'b1;
        end
      end
      done = '0;
      for (int s = 0; s < 8; s++) begin
        c = model_prev[8*s +: 8];
        if (c != 8'h00 && !in_new[c] && !done[c]) begin
          exp_q.push_back({1'b0, c});
          done[c] = 1'b1;
        end
      end
      model_held = $countones(in_new);
      model_prev = rep;
    end
  endtask

  task automatic set_vec(input int i, input logic [31:0] k0, input logic [31:0] k1, input int n,
                         input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2,
                         input logic [8:0] e3, input logic [3:0] held);
    tbl[i].k0 = k0;  tbl[i].k1 = k1;  tbl[i].n = n;
    tbl[i].ev[0] = e0; tbl[i].ev[1] = e1; tbl[i].ev[2] = e2; tbl[i].ev[3] = e3;
    tbl[i].held = held;
  endtask

  logic        v_s[20];
  logic        b_s[20];
  logic [63:0] rep;
  int          sidx;
  logic        last_ro;

  initial begin
    // Report sequence continuing from the single 0x1A press; {press,code} per event.
    set_vec(0, 32'h0000_0004, 32'h0, 2, 9'h104, 9'h01A, 9'h0,   9'h0,   4'd1);
    set_vec(1, 32'h1600_0016, 32'h0, 2, 9'h116, 9'h004, 9'h0,   9'h0,   4'd1);
    set_vec(2, 32'h0000_0000, 32'h0, 1, 9'h016, 9'h0,   9'h0,   9'h0,   4'd0);
    set_vec(3, 32'h0000_0504, 32'h0, 2, 9'h104, 9'h105, 9'h0,   9'h0,   4'd2);
    set_vec(4, 32'h0000_0405, 32'h0, 0, 9'h0,   9'h0,   9'h0,   9'h0,   4'd2);
    set_vec(5, 32'h0000_0005, 32'h0400_0000, 0, 9'h0, 9'h0, 9'h0, 9'h0, 4'd2);
    set_vec(6, 32'h0007_0006, 32'h0000_0005, 3, 9'h106, 9'h107, 9'h004, 9'h0, 4'd3);
    set_vec(7, 32'h0000_0020, 32'h0, 4, 9'h120, 9'h006, 9'h007, 9'h005, 4'd1);

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset evt_valid", 64'(evt_valid), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset held_count", 64'(held_count), 64'd0);
    check("reset rollover_cnt", 64'(rollover_cnt), 64'd0);
    check("reset evt_code", 64'(evt_code), 64'd0);
    @(posedge Clk);
    #1 reset_rtl_0 = 1'b1;

    // Single key press: exact latency and busy window
    drive(32'h0000_001A, 32'h0);
    @(posedge Clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      v_s[c] = evt_valid;
      b_s[c] = busy;
      if (c == 2) begin
        check("t1 head code", 64'(evt_code), 64'h1A);
        check("t1 head press", 64'(evt_press), 64'd1);
      end
      @(posedge Clk);
    end
    check("t1 valid after E1", 64'(v_s[1]), 64'd0);
    check("t1 valid after E2", 64'(v_s[2]), 64'd1);
    check("t1 valid after pop", 64'(v_s[3]), 64'd0);
    check("t1 busy after E0", 64'(b_s[0]), 64'd0);
    check("t1 busy after E1", 64'(b_s[1]), 64'd1);
    check("t1 busy after E17", 64'(b_s[17]), 64'd1);
    check("t1 busy after E18", 64'(b_s[18]), 64'd0);
    check("t1 held_count", 64'(held_count), 64'd1);
    exp_q.push_back(9'h11A);
    compare_events("t1");

    // Table-driven report diffs
    for (int t = 0; t < 8; t++) begin
      drive(tbl[t].k0, tbl[t].k1);
      for (int e = 0; e < tbl[t].n; e++) exp_q.push_back(tbl[t].ev[e]);
      wait_idle($sformatf("tbl%0d", t));
      compare_events($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d held_count", t), 64'(held_count), 64'(tbl[t].held));
    end

    // Full FIFO: 8 presses queue, the release of 0x20 stalls the scan
    rdy_fixed = 1'b0;
    drive(32'h0706_0504, 32'h0B0A_0908);
    repeat (30) @(negedge Clk);
    check("t3 busy while stalled", 64'(busy), 64'd1);
    check("t3 valid while stalled", 64'(evt_valid), 64'd1);
    check("t3 head stable", 64'(evt_code), 64'h04);
    @(posedge Clk);
    #1 rdy_fixed = 1'b1;
    @(posedge Clk);
    #1 rdy_fixed = 1'b0;
    repeat (20) @(negedge Clk);
    check("t3 busy after one pop", 64'(busy), 64'd0);
    check("t3 next head", 64'(evt_code), 64'h05);
    rdy_fixed = 1'b1;
    wait_idle("t3");
    for (int k = 4; k <= 11; k++) exp_q.push_back({1'b1, 8'(k)});
    exp_q.push_back(9'h020);
    compare_events("t3");
    check("t3 held_count", 64'(held_count), 64'd8);

    // Rollover reports: discarded, counted, saturating
    drive(32'h0401_0404, 32'h0404_0404);
    repeat (4) @(negedge Clk);
    check("t4 rollover first", 64'(rollover_cnt), 64'd1);
    check("t4 busy", 64'(busy), 64'd0);
    for (int n = 1; n < 259; n++) begin
      if (n % 2 == 1) drive(32'h0501_0505, 32'h0505_0505);
      else            drive(32'h0401_0404, 32'h0404_0404);
    end
    repeat (4) @(negedge Clk);
    check("t4 rollover saturated", 64'(rollover_cnt), 64'hFF);
    check("t4 held_count kept", 64'(held_count), 64'd8);
    compare_events("t4 no events");
    drive(32'h0706_0504, 32'h0B0A_0908);
    wait_idle("t4 prev");
    compare_events("t4 prev kept");

    // Asynchronous reset during the release scan with 3 presses queued
    rdy_fixed = 1'b0;
    drive(32'h070E_0D0C, 32'h0B0A_0908);
    @(posedge Clk);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    check("t6 busy before reset", 64'(busy), 64'd1);
    check("t6 head before reset", 64'(evt_code), 64'h0C);
    #1 reset_rtl_0 = 1'b0;
    #1;
    check("t6 reset evt_valid", 64'(evt_valid), 64'd0);
    check("t6 reset busy", 64'(busy), 64'd0);
    check("t6 reset held_count", 64'(held_count), 64'd0);
    check("t6 reset rollover_cnt", 64'(rollover_cnt), 64'd0);
    got_q.delete();
    @(posedge Clk);
    #1 reset_rtl_0 = 1'b1;
    rdy_fixed = 1'b1;
    wait_idle("t6");
    for (int k = 12; k <= 14; k++) exp_q.push_back({1'b1, 8'(k)});
    for (int k = 7; k <= 11; k++)  exp_q.push_back({1'b1, 8'(k)});
    compare_events("t6 re-press");
    check("t6 held_count", 64'(held_count), 64'd8);

    // Random reports with random consumer backpressure against the set-based model
    model_prev = {32'h0B0A_0908, 32'h070E_0D0C};
    model_ro   = 0;
    model_held = 8;
    last_ro    = 1'b0;
    rand_mode  = 1'b1;
    for (int r = 0; r < 40; r++) begin
      for (int s = 0; s < 8; s++)
        rep[8*s +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'(8'h02 + $urandom_range(0, 5));
      if (!last_ro && $urandom_range(0, 6) == 0) begin
        sidx = int'($urandom_range(0, 7));
        rep[8*sidx +: 8] = 8'h01;
        last_ro = 1'b1;
      end else begin
        last_ro = 1'b0;
      end
      model_report(rep);
      drive(rep[31:0], rep[63:32]);
      wait_idle($sformatf("rnd%0d", r));
      compare_events($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d held_count", r), 64'(held_count), 64'(model_held));
      check($sformatf("rnd%0d rollover_cnt", r), 64'(rollover_cnt), 64'(model_ro));
    end
    rand_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
